// File: rtl/mem_model_burst_if.sv
// Request, write-data and read-data channels of the burst memory model.
// The memory itself connects through the slave modport.
interface mem_model_burst_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [3:0]        req_len;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              busy;
   logic              err;

   modport slave (
      input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data,
      output req_ready, wr_ready, rd_valid, rd_data, rd_last, busy, err
   );

   modport master (
      output req_valid, req_write, req_addr, req_len, wr_valid, wr_data,
      input  req_ready, wr_ready, rd_valid, rd_data, rd_last, busy, err
   );
endinterface

// File: rtl/mem_model_burst.sv
// Single-port burst memory model: 1-16 beat reads/writes behind a valid/ready
// request channel, RD_LAT-cycle read pipeline, in-burst wrap and sticky range error.
module mem_model_burst #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 10,
   parameter int DEPTH     = 1024,
   parameter int RD_LAT    = 1,
   parameter int INIT_ZERO = 1
) (
   input  logic             clk,
   input  logic             rst,
   mem_model_burst_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN} state_e;

   localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [DATA_W-1:0] WORD0     = DATA_W'(8'h4D);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
   logic [RD_LAT-1:0] pipe_last_q, pipe_last_d;
   logic [DATA_W-1:0] pipe_data_q [RD_LAT];
   logic [DATA_W-1:0] pipe_data_d [RD_LAT];

   logic              in_range;
   logic [ADDR_W-1:0] addr_next;
   logic [IDX_W-1:0]  mem_idx;
   logic              mem_we;
   logic [DATA_W-1:0] arr_rdata, mem_rdata;
   logic              issue_vld, issue_last;
   logic [DATA_W-1:0] issue_data;

   // Word 0 is stored XOR-encoded in a 2-state register, so its power-up
   // value of zero reads back as WORD0 without any initialiser.
   bit   [DATA_W-1:0] word0_q;

   assign in_range  = {1'b0, addr_q} < DEPTH_EXT;
   assign addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
   assign mem_idx   = addr_q[IDX_W-1:0];
   assign mem_rdata = (mem_idx == '0) ? (word0_q ^ WORD0) : arr_rdata;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      mem_we     = 1'b0;
      issue_vld  = 1'b0;
      issue_last = 1'b0;
      issue_data = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               state_d = bus.req_write ? ST_WRITE : ST_READ;
               addr_d  = bus.req_addr;
               cnt_d   = bus.req_len;
            end
         end
         ST_WRITE: begin
            if (bus.wr_valid) begin
               mem_we = in_range;
               err_d  = err_q | ~in_range;
               addr_d = addr_next;
               cnt_d  = cnt_q - 4'd1;
               if (cnt_q == '0) state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            issue_vld  = 1'b1;
            issue_last = (cnt_q == '0);
            issue_data = in_range ? mem_rdata : '0;
            err_d      = err_q | ~in_range;
            addr_d     = addr_next;
            cnt_d      = cnt_q - 4'd1;
            if (cnt_q == '0) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (pipe_vld_q[RD_LAT-1] && pipe_last_q[RD_LAT-1]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Data registers only load on a valid beat, so rd_data holds between bursts.
   always_comb begin
      pipe_vld_d     = pipe_vld_q;
      pipe_last_d    = pipe_last_q;
      pipe_data_d    = pipe_data_q;
      pipe_vld_d[0]  = issue_vld;
      pipe_last_d[0] = issue_last;
      if (issue_vld) pipe_data_d[0] = issue_data;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_last_d[i] = pipe_last_q[i-1];
         if (pipe_vld_q[i-1]) pipe_data_d[i] = pipe_data_q[i-1];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_data_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_last_q <= pipe_last_d;
         pipe_data_q <= pipe_data_d;
      end
   end

   // NOTE: storage is deliberately left out of reset; rst must not alter the contents.
   always_ff @(posedge clk) begin
      if (mem_we && mem_idx == '0) word0_q <= bus.wr_data ^ WORD0;
   end

   if (INIT_ZERO != 0) begin : g_mem_zero
      bit [DATA_W-1:0] mem_q [DEPTH];
      always_ff @(posedge clk) begin
         if (mem_we) mem_q[mem_idx] <= bus.wr_data;
      end
      assign arr_rdata = mem_q[mem_idx];
   end else begin : g_mem_x
      logic [DATA_W-1:0] mem_q [DEPTH];
      always_ff @(posedge clk) begin
         if (mem_we) mem_q[mem_idx] <= bus.wr_data;
      end
      assign arr_rdata = mem_q[mem_idx];
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.wr_ready  = (state_q == ST_WRITE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.rd_valid  = pipe_vld_q[RD_LAT-1];
   assign bus.rd_last   = pipe_vld_q[RD_LAT-1] & pipe_last_q[RD_LAT-1];
   assign bus.rd_data   = pipe_data_q[RD_LAT-1];
   assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_model_burst.sv
// Directed bench for mem_model_burst: three configurations share one stimulus
// driver; a negedge monitor pops expected read beats from a scoreboard queue.
module tb_mem_model_burst;
   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid, req_write, wr_valid;
   logic [9:0] req_addr;
   logic [3:0] req_len;
   logic [7:0] wr_data;
   int         sel;

   always #5 clk = ~clk;

   mem_model_burst_if #(.DATA_W(8), .ADDR_W(10)) bus_a ();
   mem_model_burst_if #(.DATA_W(8), .ADDR_W(10)) bus_b ();
   mem_model_burst_if #(.DATA_W(8), .ADDR_W(10)) bus_c ();

   assign bus_a.req_valid = req_valid && (sel == 0);
   assign bus_b.req_valid = req_valid && (sel == 1);
   assign bus_c.req_valid = req_valid && (sel == 2);
   assign bus_a.wr_valid  = wr_valid && (sel == 0);
   assign bus_b.wr_valid  = wr_valid && (sel == 1);
   assign bus_c.wr_valid  = wr_valid && (sel == 2);
   assign bus_a.req_write = req_write;
   assign bus_b.req_write = req_write;
   assign bus_c.req_write = req_write;
   assign bus_a.req_addr  = req_addr;
   assign bus_b.req_addr  = req_addr;
   assign bus_c.req_addr  = req_addr;
   assign bus_a.req_len   = req_len;
   assign bus_b.req_len   = req_len;
   assign bus_c.req_len   = req_len;
   assign bus_a.wr_data   = wr_data;
   assign bus_b.wr_data   = wr_data;
   assign bus_c.wr_data   = wr_data;

   mem_model_burst #(.DEPTH(1024), .RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   mem_model_burst #(.DEPTH(1024), .RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
   mem_model_burst #(.DEPTH(1000), .RD_LAT(4)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

   logic [13:0] out_a, out_b, out_c, out_m;
   logic        req_ready_m, wr_ready_m, rd_valid_m, rd_last_m, busy_m, err_m;
   logic [7:0]  rd_data_m;

   assign out_a = {bus_a.req_ready, bus_a.wr_ready, bus_a.rd_valid, bus_a.rd_last,
                   bus_a.busy, bus_a.err, bus_a.rd_data};
   assign out_b = {bus_b.req_ready, bus_b.wr_ready, bus_b.rd_valid, bus_b.rd_last,
                   bus_b.busy, bus_b.err, bus_b.rd_data};
   assign out_c = {bus_c.req_ready, bus_c.wr_ready, bus_c.rd_valid, bus_c.rd_last,
                   bus_c.busy, bus_c.err, bus_c.rd_data};
   assign out_m = (sel == 1) ? out_b : (sel == 2) ? out_c : out_a;
   assign {req_ready_m, wr_ready_m, rd_valid_m, rd_last_m, busy_m, err_m, rd_data_m} = out_m;

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         cyc;
   } beat_t;

   beat_t exp_q [$];
   int    cyc    = 0;
   int    e0     = 0;
   int    checks = 0;
   int    errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Monitor: every presented read beat must match the head of the scoreboard.
   always @(negedge clk) begin
      beat_t b;
      if (rd_valid_m === 1'b1) begin
         check("rd_beat_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check("rd_data", 32'(rd_data_m), 32'(b.data));
            check("rd_last", 32'(rd_last_m), 32'(b.last));
            check("rd_cycle", 32'(cyc), 32'(b.cyc));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((busy_m !== 1'b0 || exp_q.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_busy", 32'(busy_m), 32'd0);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Presents a request and returns just after the accepting edge; e0 = that edge's cycle.
   task automatic issue(input logic wr, input int addr, input int len);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = 10'(addr);
      req_len   = 4'(len);
      while (req_ready_m !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("req_ready", 32'(req_ready_m), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      e0 = cyc;
   endtask

   // exp4 holds up to four expected bytes, first beat in the top byte.
   task automatic read_start(input int addr, input int len, input int lat, input logic [31:0] exp4);
      issue(1'b0, addr, len);
      for (int i = 0; i <= len && i < 4; i++)
         exp_q.push_back('{data: exp4[31-8*i -: 8], last: (i == len), cyc: e0 + i + lat});
   endtask

   task automatic read4(input int addr, input int len, input int lat, input logic [31:0] exp4);
      read_start(addr, len, lat, exp4);
      wait_idle();
   endtask

   task automatic write4(input int addr, input int len, input logic [31:0] d4, input int gap_after);
      issue(1'b1, addr, len);
      for (int i = 0; i <= len; i++) begin
         wr_valid = 1'b1;
         wr_data  = d4[31-8*i -: 8];
         @(posedge clk);
         #1;
         if (i == gap_after) begin
            wr_valid = 1'b0;
            wr_data  = 8'hEE;
            @(negedge clk);
            check("wr_ready_in_gap", 32'(wr_ready_m), 32'd1);
            @(posedge clk);
            #1;
         end
      end
      wr_valid = 1'b0;
      wait_idle();
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
      wr_valid = 1'b0; wr_data = '0; sel = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_req_ready", 32'(req_ready_m), 32'd1);
      check("rst_wr_ready", 32'(wr_ready_m), 32'd0);
      check("rst_rd_valid", 32'(rd_valid_m), 32'd0);
      check("rst_rd_data", 32'(rd_data_m), 32'd0);
      check("rst_rd_last", 32'(rd_last_m), 32'd0);
      check("rst_busy", 32'(busy_m), 32'd0);
      check("rst_err", 32'(err_m), 32'd0);

      // Config A: RD_LAT=1, DEPTH=1024
      read4(0, 0, 1, 32'h4D00_0000);
      read4(4, 0, 1, 32'h0000_0000);
      write4(10, 3, 32'hA1A2_A3A4, 1);
      read4(10, 3, 1, 32'hA1A2_A3A4);
      check("rd_data_hold", 32'(rd_data_m), 32'hA4);
      write4(1022, 3, 32'hB1B2_B3B4, -1);
      read4(1022, 3, 1, 32'hB1B2_B3B4);
      read4(0, 0, 1, 32'hB300_0000);
      check("wrap_err", 32'(err_m), 32'd0);

      // Config B: RD_LAT=3
      sel = 1;
      read4(0, 0, 3, 32'h4D00_0000);
      write4(10, 3, 32'hA1A2_A3A4, -1);
      read4(10, 3, 3, 32'hA1A2_A3A4);

      // Config C: DEPTH=1000, RD_LAT=4
      sel = 2;
      write4(998, 1, 32'hC1C2_0000, -1);
      read4(999, 1, 4, 32'hC24D_0000);
      check("edge_wrap_err", 32'(err_m), 32'd0);
      read_start(1000, 1, 4, 32'h0000_0000);
      check("oob_err_before", 32'(err_m), 32'd0);
      @(posedge clk);
      #1;
      check("oob_err_next", 32'(err_m), 32'd1);
      wait_idle();
      write4(1005, 0, 32'hEE00_0000, -1);
      read4(998, 0, 4, 32'hC100_0000);
      check("oob_err_sticky", 32'(err_m), 32'd1);

      // Reset in the 6th cycle of a 16-beat read: only beats 0 and 1 are presented
      issue(1'b0, 0, 15);
      exp_q.push_back('{data: 8'h4D, last: 1'b0, cyc: e0 + 4});
      exp_q.push_back('{data: 8'h00, last: 1'b0, cyc: e0 + 5});
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_rd_valid", 32'(rd_valid_m), 32'd0);
      check("midrst_req_ready", 32'(req_ready_m), 32'd1);
      check("midrst_busy", 32'(busy_m), 32'd0);
      check("midrst_err", 32'(err_m), 32'd0);
      rst = 1'b0;
      read4(999, 0, 4, 32'hC200_0000);
      sel = 0;
      read4(10, 0, 1, 32'hA100_0000);

      // Back-to-back writes with req_valid held high
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd20; req_len = 4'd0;
      wr_valid  = 1'b1; wr_data = 8'h5A;
      check("b2b_ready_first", 32'(req_ready_m), 32'd1);
      @(negedge clk);
      check("b2b_ready_busy", 32'(req_ready_m), 32'd0);
      req_addr = 10'd21;
      @(negedge clk);
      check("b2b_ready_back", 32'(req_ready_m), 32'd1);
      check("wr_ready_idle", 32'(wr_ready_m), 32'd0);
      wr_data = 8'h5B;
      @(negedge clk);
      check("b2b_second_busy", 32'(busy_m), 32'd1);
      req_valid = 1'b0;
      @(negedge clk);
      wr_valid = 1'b0;
      check("b2b_done", 32'(busy_m), 32'd0);
      read4(20, 1, 1, 32'h5A5B_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
